// File: rtl/mips_regfile_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the single-cycle MIPS register file slice.
//   DATA_WIDTH / ADDR_WIDTH / NUM_REGS : register file geometry
//   REG_ZERO                           : hardwired-zero register index ($0)
//   REG_RA                             : return-address register index ($31)
//   rdSrc_e                            : where a read port takes its data from
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

   // A read port returns either a forced zero, the word being written this
   // cycle, or the word already held in storage.
   typedef enum logic [1:0] {
      RD_ZERO    = 2'd0,
      RD_BYPASS  = 2'd1,
      RD_STORAGE = 2'd2
   } rdSrc_e;

endpackage : mips_pkg

// File: rtl/mips_regfile_if.sv
// -----------------------------------------------------------------------------
// mips_regfile_if
// Bundles the register file read and write ports.
//   rs_addr / rt_addr : read port A / B index
//   rs_data / rt_data : read port A / B data (combinational)
//   wr_en             : RegWrite control
//   wr_addr           : write index (RegDst mux output)
//   wr_data           : write data (write-back mux output)
// master = datapath side driving addresses and write data,
// slave  = the register file itself.
// -----------------------------------------------------------------------------
interface mips_regfile_if #(
   parameter int DW = mips_pkg::DATA_WIDTH,
   parameter int AW = mips_pkg::ADDR_WIDTH
);

   logic [AW-1:0] rs_addr;
   logic [AW-1:0] rt_addr;
   logic [DW-1:0] rs_data;
   logic [DW-1:0] rt_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output rs_addr, rt_addr, wr_en, wr_addr, wr_data,
      input  rs_data, rt_data
   );

   modport slave (
      input  rs_addr, rt_addr, wr_en, wr_addr, wr_data,
      output rs_data, rt_data
   );

endinterface : mips_regfile_if

// File: rtl/mips_regfile_rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file. Chooses between a forced
// zero, the in-flight write data (bypass) and the stored word.
//   addr_i    : register index being read
//   word_i    : stored word at addr_i (ignored for index 0)
//   wr_en_i   : RegWrite control
//   wr_addr_i : write index
//   wr_data_i : write data
//   reset_i   : synchronous reset, forces the output to zero while high
//   data_o    : read data
// -----------------------------------------------------------------------------
module rf_read_port #(
   parameter int WIDTH  = mips_pkg::DATA_WIDTH,
   parameter int AWIDTH = mips_pkg::ADDR_WIDTH
) (
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0]  word_i,
   input  logic              wr_en_i,
   input  logic [AWIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              reset_i,
   output logic [WIDTH-1:0]  data_o
);

   import mips_pkg::*;

   rdSrc_e rdSrc;

   // Pick the data source. Reset and $0 both win over bypass; once addr_i is
   // known non-zero, an address match implies the write target is non-zero
   // too, so the bypass needs no separate zero check on wr_addr_i.
   always_comb begin
      rdSrc = RD_STORAGE;
      if (reset_i || (addr_i == '0)) begin
         rdSrc = RD_ZERO;
      end else if (wr_en_i && (wr_addr_i == addr_i)) begin
         rdSrc = RD_BYPASS;
      end
   end

   // Steer the selected source onto the output.
   always_comb begin
      data_o = '0;
      case (rdSrc)
         RD_BYPASS:  data_o = wr_data_i;
         RD_STORAGE: data_o = word_i;
         default:    data_o = '0;
      endcase
   end

endmodule : rf_read_port

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports, one synchronous write port, $0 hardwired to
// zero, same-cycle write-to-read bypass.
//   clk   : system clock, state updates on the rising edge
//   reset : synchronous active-high, clears every register
//   rf    : slave side of mips_regfile_if (read/write ports)
// -----------------------------------------------------------------------------
module mips_regfile #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH
) (
   input  logic         clk,
   input  logic         reset,
   mips_regfile_if.slave rf
);

   localparam int NumRegs = 2 ** ADDR_WIDTH;

   // Entry 0 has no storage at all; it is a constant zero.
   logic [DATA_WIDTH-1:0] regs_q [NumRegs-1:1];
   logic [DATA_WIDTH-1:0] regs_d [NumRegs-1:1];

   logic                  wrFire;
   logic [DATA_WIDTH-1:0] rsWord;
   logic [DATA_WIDTH-1:0] rtWord;

   // A write only counts when it targets a real register; writes to $0 are
   // dropped here so neither storage nor bypass ever sees them.
   assign wrFire = rf.wr_en && (rf.wr_addr != ADDR_WIDTH'(mips_pkg::REG_ZERO));

   // Next-state for every stored register: hold, or take the write data when
   // this entry is the write target.
   always_comb begin
      for (int i = 1; i < NumRegs; i++) begin
         regs_d[i] = regs_q[i];
         if (wrFire && (rf.wr_addr == ADDR_WIDTH'(i))) begin
            regs_d[i] = rf.wr_data;
         end
      end
   end

   // Storage update. Reset has priority, so a write presented together with
   // reset is lost.
   always_ff @(posedge clk) begin
      for (int i = 1; i < NumRegs; i++) begin
         if (reset) begin
            regs_q[i] <= '0;
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Fetch the stored words for both read ports. Index 0 has no storage
   // entry, so it is steered to zero before indexing.
   always_comb begin
      rsWord = '0;
      rtWord = '0;
      if (rf.rs_addr != '0) begin
         rsWord = regs_q[rf.rs_addr];
      end
      if (rf.rt_addr != '0) begin
         rtWord = regs_q[rf.rt_addr];
      end
   end

   rf_read_port #(
      .WIDTH  (DATA_WIDTH),
      .AWIDTH (ADDR_WIDTH)
   ) u_portA (
      .addr_i    (rf.rs_addr),
      .word_i    (rsWord),
      .wr_en_i   (rf.wr_en),
      .wr_addr_i (rf.wr_addr),
      .wr_data_i (rf.wr_data),
      .reset_i   (reset),
      .data_o    (rf.rs_data)
   );

   rf_read_port #(
      .WIDTH  (DATA_WIDTH),
      .AWIDTH (ADDR_WIDTH)
   ) u_portB (
      .addr_i    (rf.rt_addr),
      .word_i    (rtWord),
      .wr_en_i   (rf.wr_en),
      .wr_addr_i (rf.wr_addr),
      .wr_data_i (rf.wr_data),
      .reset_i   (reset),
      .data_o    (rf.rt_data)
   );

   // An unknown write index with RegWrite high means the upstream RegDst path
   // is broken; the resulting write target would be meaningless.
   wrAddrKnown: assert property (@(posedge clk) disable iff (reset)
      rf.wr_en |-> !$isunknown(rf.wr_addr));

endmodule : mips_regfile

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Sits directly downstream of the 32-bit 2:1 write-back select mux (ALU result vs memory data, select = MemtoReg), which drives the write-data port.
- Its read ports feed the ALU operand path and the ALUSrc mux.
- Two combinational read ports, one synchronous write port, $0 hardwired to zero, same-cycle write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- rs_addr  input  ADDR_WIDTH  read port A index (instr[25:21])
- rt_addr  input  ADDR_WIDTH  read port B index (instr[20:16])
- rs_data  output  DATA_WIDTH  read port A data
- rt_data  output  DATA_WIDTH  read port B data
- wr_en  input  1  RegWrite control
- wr_addr  input  ADDR_WIDTH  write index (output of RegDst mux)
- wr_data  input  DATA_WIDTH  write data (output of write-back mux)

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On a rising clk edge with reset=1, all registers become 0. wr_en is ignored in that cycle.
- Reset value of outputs:
  - rs_data and rt_data are combinational.
  - While reset=1 they are forced to 0 regardless of address or bypass.
  - After reset they read 0 until written.
- Write:
  - On a rising clk edge with reset=0, wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Writes to index 0 are discarded. reg[0] is never stored; it is a constant 0.
- Read:
  - Zero latency: data = reg[addr] combinationally.
  - addr==0 always returns 0, including when a write to 0 is in flight.
- Bypass (write-before-read):
  - If wr_en=1, wr_addr!=0, reset=0 and wr_addr==rs_addr, then rs_data = wr_data in the same cycle. rt_data is handled identically and independently.
  - The registered value is updated at the next edge, so the following cycle reads the same value from storage.
- Simultaneous events:
  - Both read ports may address the same register and the write address at once; both bypass.
  - reset and wr_en together: reset wins, and no write or bypass occurs.
- Reset mid-operation:
  - Contents are lost at the edge where reset is sampled high.
  - There is no partial state; the first post-reset write behaves normally.
- X handling: X on wr_addr with wr_en=1 is a bench error, flagged by an assertion. RTL behaviour is then undefined.
- No stalls or handshake. The write is a single-cycle fire on wr_en.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_WIDTH=32, ADDR_WIDTH=5, NUM_REGS=32
  - REG_ZERO=5'd0, REG_RA=5'd31
- Storage array and write logic live in mips_regfile.
- One natural sub-module, rf_read_port, is instantiated twice (A and B).
  - Inputs: addr, storage word, wr_en, wr_addr, wr_data, reset.
  - It implements the zero-index check, the bypass compare and the reset force-to-zero.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert reset 1 cycle, read rs_addr=5 -> rs_data=0x00000000 during and after reset.
- Basic write/read: wr_en=1, wr_addr=8, wr_data=0x12345678 at edge; next cycle rs_addr=8, rt_addr=8 -> both 0x12345678. Other registers (e.g. r9) still 0.
- $0 hardwired: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; same and next cycle rs_addr=0 -> 0x00000000, no bypass.
- Bypass: r3 holds 0x00000011; same cycle wr_en=1, wr_addr=3, wr_data=0x00000022, rs_addr=3, rt_addr=4 -> rs_data=0x00000022, rt_data=reg[4]. Next cycle rs_data=0x00000022 from storage.
- Reset beats write: reset=1 and wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 -> r7=0 after edge, rs_data(7)=0 during reset.
- Full sweep: write r1..r31 with value (i<<16)|i on consecutive cycles, then read all pairs (i, 32-i) -> each port returns its own pattern, with no aliasing at r31 (wr_addr wrap-around boundary).
